// File: rtl/bus_host_arbiter_if.sv
// Signal bundle between the upstream hosts, the arbiter and the single bus host port.
// The arbiter attaches through the slave modport; the environment drives through master.
interface bus_host_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    localparam int BeWidth = DataWidth / 8;

    // Upstream requesters, one lane per host
    logic [NrHosts-1:0]                   host_req_i;
    logic [NrHosts-1:0]                   host_gnt_o;
    logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
    logic [NrHosts-1:0]                   host_we_i;
    logic [NrHosts-1:0][BeWidth-1:0]      host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
    logic [NrHosts-1:0]                   host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;
    logic [NrHosts-1:0]                   host_err_o;

    // Single host port of the bus
    logic                                 out_req_o;
    logic [AddressWidth-1:0]              out_addr_o;
    logic                                 out_we_o;
    logic [BeWidth-1:0]                   out_be_o;
    logic [DataWidth-1:0]                 out_wdata_o;
    logic                                 out_gnt_i;
    logic                                 out_rvalid_i;
    logic [DataWidth-1:0]                 out_rdata_i;
    logic                                 out_err_i;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o
    );
endinterface

// File: rtl/bus_host_arbiter.sv
// Shares one bus host port among NrHosts requesters and routes in-order responses back by ID FIFO.
// BUS_HOST_ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bus_host_arbiter_if.slave bus_if,
    output logic              protocol_err_o
);
    localparam int BeWidth  = DataWidth / 8;
    localparam int IdWidth  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    localparam logic [0:0] LOCK_FREE = 1'b0;
    localparam logic [0:0] LOCK_HELD = 1'b1;

    logic [IdWidth-1:0]      id_mem [MaxOutstanding];
    logic [PtrWidth-1:0]     rd_ptr;
    logic [PtrWidth-1:0]     wr_ptr;
    logic [CntWidth-1:0]     count;
    logic [0:0]              lock_state;
    logic [IdWidth-1:0]      lock_id;

    logic                    any_req;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    out_req;
    logic                    lock_hit;
    logic                    push;
    logic                    pop;
    logic                    spurious;
    logic [IdWidth-1:0]      arb_start;
    logic [IdWidth-1:0]      arb_sel;
    logic [IdWidth-1:0]      sel;
    logic [IdWidth-1:0]      head;
    logic [AddressWidth-1:0] sel_addr;
    logic [BeWidth-1:0]      sel_be;
    logic [DataWidth-1:0]    sel_wdata;

    // First requesting host at or after start, wrapping at NrHosts.
    function automatic logic [IdWidth-1:0] first_from(input logic [NrHosts-1:0] req,
                                                     input logic [IdWidth-1:0] start);
        logic [IdWidth-1:0] idx;
        first_from = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            idx = IdWidth'((int'(start) + i) % NrHosts);
            if (req[idx]) first_from = idx;
        end
    endfunction

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

`ifdef BUS_HOST_ARB_ROUND_ROBIN_EN
    logic [IdWidth-1:0] rr_ptr;
    assign arb_start = rr_ptr;
`else
    assign arb_start = '0;
`endif

    // A full FIFO blocks even when a pop lands in the same cycle, keeping rvalid off the req path.
    assign any_req    = |bus_if.host_req_i;
    assign fifo_full  = (count == CntWidth'(MaxOutstanding));
    assign fifo_empty = (count == '0);
    assign out_req    = any_req && !fifo_full;

    assign lock_hit   = (lock_state == LOCK_HELD) && bus_if.host_req_i[lock_id];
    assign arb_sel    = first_from(bus_if.host_req_i, arb_start);
    assign sel        = lock_hit ? lock_id : arb_sel;

    assign push       = out_req && bus_if.out_gnt_i;
    assign head       = id_mem[rd_ptr];
    assign pop        = bus_if.out_rvalid_i && !fifo_empty;
    assign spurious   = bus_if.out_rvalid_i && fifo_empty;

    assign sel_addr   = bus_if.host_addr_i[sel];
    assign sel_be     = bus_if.host_be_i[sel];
    assign sel_wdata  = bus_if.host_wdata_i[sel];

    // Request path: mux the selected host onto the bus, grant only that host.
    always_comb begin
        // NOTE: every output gets a default before any condition, so no path leaves a latch.
        bus_if.out_req_o   = out_req;
        bus_if.out_addr_o  = '0;
        bus_if.out_we_o    = 1'b0;
        bus_if.out_be_o    = '0;
        bus_if.out_wdata_o = '0;
        bus_if.host_gnt_o  = '0;
        if (out_req) begin
            bus_if.out_addr_o  = sel_addr;
            bus_if.out_we_o    = bus_if.host_we_i[sel];
            bus_if.out_be_o    = sel_be;
            bus_if.out_wdata_o = sel_wdata;
        end
        if (push) bus_if.host_gnt_o[sel] = 1'b1;
    end

    // Response path: data is broadcast, valid/err go only to the FIFO head owner.
    always_comb begin
        bus_if.host_rvalid_o = '0;
        bus_if.host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            bus_if.host_rdata_o[h] = bus_if.out_rdata_i;
        end
        if (pop) begin
            bus_if.host_rvalid_o[head] = 1'b1;
            bus_if.host_err_o[head]    = bus_if.out_err_i;
        end
    end

    // NOTE: entries are only read while count says they are valid, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr] <= sel;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + CntWidth'(1);
            else if (pop && !push) count <= count - CntWidth'(1);
        end
    end

    // Hold the chosen host while its request waits for gnt; a dropped request simply re-arbitrates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_state <= LOCK_FREE;
            lock_id    <= '0;
        end else if (out_req && !bus_if.out_gnt_i) begin
            lock_state <= LOCK_HELD;
            lock_id    <= sel;
        end else begin
            lock_state <= LOCK_FREE;
        end
    end

`ifdef BUS_HOST_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (sel == IdWidth'(NrHosts - 1)) ? '0 : sel + IdWidth'(1);
        end
    end
`endif

    // Sticky: a response with nothing in flight means host and bus disagree.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            protocol_err_o <= 1'b0;
        end else if (spurious) begin
            protocol_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: constant vector table, directed corner sequences,
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_bus_host_arbiter;
    localparam int NrHosts        = 2;
    localparam int DataWidth      = 32;
    localparam int AddressWidth   = 32;
    localparam int MaxOutstanding = 2;
    localparam int BeWidth        = DataWidth / 8;
`ifdef BUS_HOST_ARB_ROUND_ROBIN_EN
    localparam bit RrMode = 1'b1;
`else
    localparam bit RrMode = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    logic protocol_err_o;
    int   checks = 0;
    int   errors = 0;

    bus_host_arbiter_if #(
        .NrHosts(NrHosts), .DataWidth(DataWidth), .AddressWidth(AddressWidth)
    ) bus_if ();

    bus_host_arbiter #(
        .NrHosts(NrHosts), .DataWidth(DataWidth), .AddressWidth(AddressWidth),
        .MaxOutstanding(MaxOutstanding)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus_if(bus_if),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NrHosts-1:0] req;
        logic               gnt;
        logic               rvalid;
        logic [31:0]        rdata;
        logic [NrHosts-1:0] exp_gnt;
        logic [NrHosts-1:0] exp_rvalid;
        logic               exp_out_req;
    } vec_t;

    vec_t vecs[6];

    // Reference model state: in-flight owners in issue order, lock owner, arbitration pointer.
    int id_q[$];
    int lock_m;
    bit perr_m;
    int rr_ptr_m;
    int sel_m;
    bit oreq_m;
    bit push_m;
    bit pop_m;
    bit spur_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [NrHosts-1:0] req, input logic gnt, input logic rvalid,
                                input logic [31:0] rdata, input logic [NrHosts-1:0] exp_gnt,
                                input logic [NrHosts-1:0] exp_rvalid, input logic exp_out_req);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
        v.exp_gnt = exp_gnt; v.exp_rvalid = exp_rvalid; v.exp_out_req = exp_out_req;
        return v;
    endfunction

    task automatic drive_idle();
        bus_if.host_req_i   = '0;
        bus_if.host_addr_i  = '0;
        bus_if.host_we_i    = '0;
        bus_if.host_be_i    = '0;
        bus_if.host_wdata_i = '0;
        bus_if.out_gnt_i    = 1'b0;
        bus_if.out_rvalid_i = 1'b0;
        bus_if.out_rdata_i  = '0;
        bus_if.out_err_i    = 1'b0;
    endtask

    // Compute what the rules demand for the current inputs and compare every output.
    task automatic model_check();
        int sel;
        logic [NrHosts-1:0] gnt_e;
        logic [NrHosts-1:0] rv_e;
        logic [NrHosts-1:0] err_e;
        bit oreq;
        oreq = (|bus_if.host_req_i) && (id_q.size() < MaxOutstanding);
        sel = -1;
        if (lock_m >= 0 && bus_if.host_req_i[lock_m]) begin
            sel = lock_m;
        end else begin
            for (int k = 0; k < NrHosts; k++) begin
                int h;
                h = RrMode ? (rr_ptr_m + k) % NrHosts : k;
                if (sel < 0 && bus_if.host_req_i[h]) sel = h;
            end
        end
        gnt_e = '0;
        if (oreq && bus_if.out_gnt_i) gnt_e[sel] = 1'b1;
        rv_e  = '0;
        err_e = '0;
        if (bus_if.out_rvalid_i && id_q.size() > 0) begin
            rv_e[id_q[0]]  = 1'b1;
            err_e[id_q[0]] = bus_if.out_err_i;
        end
        check("out_req", 64'(bus_if.out_req_o), 64'(oreq));
        check("host_gnt", 64'(bus_if.host_gnt_o), 64'(gnt_e));
        if (oreq) begin
            check("out_addr", 64'(bus_if.out_addr_o), 64'(bus_if.host_addr_i[sel]));
            check("out_we", 64'(bus_if.out_we_o), 64'(bus_if.host_we_i[sel]));
            check("out_be", 64'(bus_if.out_be_o), 64'(bus_if.host_be_i[sel]));
            check("out_wdata", 64'(bus_if.out_wdata_o), 64'(bus_if.host_wdata_i[sel]));
        end
        check("host_rvalid", 64'(bus_if.host_rvalid_o), 64'(rv_e));
        check("host_err", 64'(bus_if.host_err_o), 64'(err_e));
        for (int h = 0; h < NrHosts; h++) begin
            check("host_rdata", 64'(bus_if.host_rdata_o[h]), 64'(bus_if.out_rdata_i));
        end
        check("protocol_err", 64'(protocol_err_o), 64'(perr_m));
        sel_m  = sel;
        oreq_m = oreq;
        push_m = oreq && bus_if.out_gnt_i;
        pop_m  = bus_if.out_rvalid_i && (id_q.size() > 0);
        spur_m = bus_if.out_rvalid_i && (id_q.size() == 0);
    endtask

    task automatic model_update();
        if (pop_m) void'(id_q.pop_front());
        if (push_m) begin
            id_q.push_back(sel_m);
            rr_ptr_m = (sel_m + 1) % NrHosts;
            lock_m   = -1;
        end else begin
            lock_m = oreq_m ? sel_m : -1;
        end
        if (spur_m) perr_m = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic finish_cycle();
        model_check();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic cycle();
        settle();
        finish_cycle();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("rst_out_req", 64'(bus_if.out_req_o), 64'd0);
            check("rst_gnt", 64'(bus_if.host_gnt_o), 64'd0);
            check("rst_rvalid", 64'(bus_if.host_rvalid_o), 64'd0);
            check("rst_err", 64'(bus_if.host_err_o), 64'd0);
            check("rst_addr", 64'(bus_if.out_addr_o), 64'd0);
            check("rst_wdata", 64'(bus_if.out_wdata_o), 64'd0);
            check("rst_protocol_err", 64'(protocol_err_o), 64'd0);
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b0;
        id_q.delete();
        lock_m   = -1;
        rr_ptr_m = 0;
        perr_m   = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        drive_idle();
        id_q.delete();
        lock_m = -1; rr_ptr_m = 0; perr_m = 1'b0;

        // Contention table: both hosts request, bus grants every cycle and answers one cycle later.
        vecs[0] = mk(2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1);
        if (RrMode) begin
            vecs[1] = mk(2'b11, 1'b1, 1'b1, 32'hA000_0000, 2'b10, 2'b01, 1'b1);
            vecs[2] = mk(2'b11, 1'b1, 1'b1, 32'hA000_0001, 2'b01, 2'b10, 1'b1);
            vecs[3] = mk(2'b11, 1'b1, 1'b1, 32'hA000_0002, 2'b10, 2'b01, 1'b1);
            vecs[4] = mk(2'b11, 1'b1, 1'b1, 32'hA000_0003, 2'b01, 2'b10, 1'b1);
        end else begin
            vecs[1] = mk(2'b11, 1'b1, 1'b1, 32'hA000_0000, 2'b01, 2'b01, 1'b1);
            vecs[2] = mk(2'b11, 1'b1, 1'b1, 32'hA000_0001, 2'b01, 2'b01, 1'b1);
            vecs[3] = mk(2'b11, 1'b1, 1'b1, 32'hA000_0002, 2'b01, 2'b01, 1'b1);
            vecs[4] = mk(2'b11, 1'b1, 1'b1, 32'hA000_0003, 2'b01, 2'b01, 1'b1);
        end
        vecs[5] = mk(2'b00, 1'b1, 1'b1, 32'hA000_0004, 2'b00, 2'b01, 1'b0);

        // Reset, then confirm nothing is requested after release.
        do_reset();
        cycle();
        cycle();

        bus_if.host_addr_i[0] = 32'h0000_0100;
        bus_if.host_addr_i[1] = 32'h0000_0200;
        for (int r = 0; r < 6; r++) begin
            bus_if.host_req_i   = vecs[r].req;
            bus_if.out_gnt_i    = vecs[r].gnt;
            bus_if.out_rvalid_i = vecs[r].rvalid;
            bus_if.out_rdata_i  = vecs[r].rdata;
            bus_if.out_err_i    = 1'b0;
            settle();
            check("tbl_out_req", 64'(bus_if.out_req_o), 64'(vecs[r].exp_out_req));
            check("tbl_gnt", 64'(bus_if.host_gnt_o), 64'(vecs[r].exp_gnt));
            check("tbl_rvalid", 64'(bus_if.host_rvalid_o), 64'(vecs[r].exp_rvalid));
            for (int h = 0; h < NrHosts; h++) begin
                if (vecs[r].exp_rvalid[h]) begin
                    check("tbl_rdata", 64'(bus_if.host_rdata_o[h]), 64'(vecs[r].rdata));
                end
            end
            finish_cycle();
        end
        drive_idle();
        cycle();

        // Lock: host 1 waits four cycles without gnt, host 0 joins in cycle 2, host 1 still wins.
        do_reset();
        bus_if.host_addr_i[0] = 32'h0000_0040;
        bus_if.host_addr_i[1] = 32'h0010_0010;
        for (int c = 0; c < 5; c++) begin
            bus_if.host_req_i = (c >= 2) ? 2'b11 : 2'b10;
            bus_if.out_gnt_i  = (c == 4);
            settle();
            check("lock_addr", 64'(bus_if.out_addr_o), 64'h0010_0010);
            check("lock_gnt", 64'(bus_if.host_gnt_o), (c == 4) ? 64'd2 : 64'd0);
            finish_cycle();
        end
        bus_if.host_req_i   = 2'b01;
        bus_if.out_gnt_i    = 1'b1;
        bus_if.out_rvalid_i = 1'b1;
        bus_if.out_rdata_i  = 32'h0000_0011;
        settle();
        check("lock_next_gnt", 64'(bus_if.host_gnt_o), 64'd1);
        check("lock_resp_owner", 64'(bus_if.host_rvalid_o), 64'd2);
        finish_cycle();
        bus_if.host_req_i = 2'b00;
        settle();
        check("lock_resp2_owner", 64'(bus_if.host_rvalid_o), 64'd1);
        finish_cycle();
        drive_idle();
        cycle();

        // Full FIFO: two grants without responses, request blocked until a response drains one.
        do_reset();
        bus_if.out_gnt_i  = 1'b1;
        bus_if.host_req_i = 2'b01;
        settle();
        check("full_g0", 64'(bus_if.host_gnt_o), 64'd1);
        finish_cycle();
        bus_if.host_req_i = 2'b10;
        settle();
        check("full_g1", 64'(bus_if.host_gnt_o), 64'd2);
        finish_cycle();
        bus_if.host_req_i = 2'b01;
        settle();
        check("full_blocked", 64'(bus_if.out_req_o), 64'd0);
        finish_cycle();
        bus_if.out_rvalid_i = 1'b1;
        bus_if.out_rdata_i  = 32'hDEAD_0001;
        bus_if.out_err_i    = 1'b0;
        settle();
        check("full_blocked_on_pop", 64'(bus_if.out_req_o), 64'd0);
        check("full_r1_owner", 64'(bus_if.host_rvalid_o), 64'd1);
        check("full_r1_err", 64'(bus_if.host_err_o), 64'd0);
        check("full_r1_data", 64'(bus_if.host_rdata_o[0]), 64'hDEAD_0001);
        finish_cycle();
        bus_if.out_rdata_i = 32'hDEAD_0002;
        bus_if.out_err_i   = 1'b1;
        settle();
        check("full_reissue", 64'(bus_if.out_req_o), 64'd1);
        check("full_r2_owner", 64'(bus_if.host_rvalid_o), 64'd2);
        check("full_r2_err", 64'(bus_if.host_err_o), 64'd2);
        check("full_r2_data", 64'(bus_if.host_rdata_o[1]), 64'hDEAD_0002);
        finish_cycle();
        bus_if.host_req_i  = 2'b00;
        bus_if.out_rdata_i = 32'hDEAD_0003;
        bus_if.out_err_i   = 1'b0;
        cycle();
        drive_idle();
        cycle();

        // Reset with a grant in flight, then the late response is spurious and sticks.
        do_reset();
        bus_if.host_req_i = 2'b01;
        bus_if.out_gnt_i  = 1'b1;
        cycle();
        do_reset();
        bus_if.out_rvalid_i = 1'b1;
        bus_if.out_rdata_i  = 32'h0BAD_0BAD;
        settle();
        check("spur_no_rvalid", 64'(bus_if.host_rvalid_o), 64'd0);
        finish_cycle();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            settle();
            check("spur_sticky", 64'(protocol_err_o), 64'd1);
            finish_cycle();
        end

        // Randomized traffic against the model, responses only while something is in flight.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                bus_if.host_req_i = NrHosts'($urandom);
                for (int h = 0; h < NrHosts; h++) begin
                    bus_if.host_addr_i[h]  = AddressWidth'($urandom);
                    bus_if.host_we_i[h]    = 1'($urandom);
                    bus_if.host_be_i[h]    = BeWidth'($urandom);
                    bus_if.host_wdata_i[h] = DataWidth'($urandom);
                end
                bus_if.out_gnt_i    = ($urandom_range(0, 3) != 0);
                bus_if.out_rvalid_i = (id_q.size() > 0) && ($urandom_range(0, 2) != 0);
                bus_if.out_rdata_i  = DataWidth'($urandom);
                bus_if.out_err_i    = ($urandom_range(0, 4) == 0);
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_host_arbiter.md
# bus_host_arbiter

Multi-host request arbiter placed in front of a single host port of `bus`. It lets the core data port and additional requesters (debug module, DMA) share one bus master slot without changing `bus`. It grants one request per cycle under round-robin or fixed priority. It tracks in-flight transactions in an in-order ID FIFO so each `rvalid`/`rdata`/`err` returns to the host that issued it.

## Interface
Parameters:
- `NrHosts`, 2, number of upstream requesters (2..8).
- `DataWidth`, 32, data bus width.
- `AddressWidth`, 32, address bus width.
- `MaxOutstanding`, 2, depth of the ID FIFO, i.e. maximum granted-but-unanswered transactions (1..8).

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `host_req_i`  in  1 x NrHosts  request per host.
- `host_gnt_o`  out  1 x NrHosts  grant per host.
- `host_addr_i`  in  AddressWidth x NrHosts  address.
- `host_we_i`  in  1 x NrHosts  write enable.
- `host_be_i`  in  DataWidth/8 x NrHosts  byte enables.
- `host_wdata_i`  in  DataWidth x NrHosts  write data.
- `host_rvalid_o`  out  1 x NrHosts  response valid, owner only.
- `host_rdata_o`  out  DataWidth x NrHosts  response data, broadcast.
- `host_err_o`  out  1 x NrHosts  response error, owner only.
- `out_req_o`, `out_addr_o`, `out_we_o`, `out_be_o`, `out_wdata_o`  out  request toward the `bus` host port.
- `out_gnt_i`, `out_rvalid_i`, `out_rdata_i`, `out_err_i`  in  handshake and response from the `bus` host port.
- `protocol_err_o`  out  1  sticky flag: `out_rvalid_i` arrived while the ID FIFO was empty.

## Operation
- **Request/response protocol:** OBI-style. A request is accepted on a cycle with req && gnt. Exactly one response per accepted request, in order.
- **Blocking:** `out_req_o` = (any `host_req_i`) && !fifo_full.
- **Arbitration:** when not locked, `sel` is the first requesting host at or after `rr_ptr`, in wrapping order.
- **Lock:** if `out_req_o` is high and `out_gnt_i` is low, the `lock` register holds `sel` until that host is granted. Address and data stay stable for the pending request. A locked host dropping `host_req_i` releases the lock; this is a protocol violation and is not flagged.
- **Request mux:** `out_addr/we/be/wdata` are taken from `sel`.
- **Grant:** `host_gnt_o[sel]` = `out_req_o` && `out_gnt_i`. All other grants are 0.
- **On grant:**
  - push `sel` into the ID FIFO;
  - `rr_ptr` <= (`sel`+1) mod NrHosts;
  - clear `lock`.
- **On `out_rvalid_i`:**
  - pop the FIFO head `h`;
  - `host_rvalid_o[h]` = 1 and `host_err_o[h]` = `out_err_i`;
  - `host_rdata_o[*]` = `out_rdata_i`.
- **Simultaneous push and pop:** both take effect and the occupancy count is unchanged.
- **Full FIFO:** the request is blocked even if a pop occurs in the same cycle. This avoids a combinational path from `out_rvalid_i` to `out_req_o`.
- **Spurious response:** `out_rvalid_i` with the FIFO empty drives no `host_rvalid_o` and sets `protocol_err_o`, which stays set until reset.
- **FIFO storage:** circular buffer with read and write pointers mod MaxOutstanding, plus an occupancy counter of width $clog2(MaxOutstanding+1).

## Timing
- **Reset values:** all outputs 0; FIFO empty; `rr_ptr` = 0; `lock` clear; `protocol_err_o` = 0.
- **Reset mid-transaction:** in-flight IDs are discarded, and the first response after reset raises `protocol_err_o`. The bus must be reset together with this block.
- **Added latency:** zero cycles for both paths.
  - Request path: `host_req_i` to `out_req_o`, and `out_gnt_i` to `host_gnt_o`, are combinational.
  - Response path: `out_rvalid_i` to `host_rvalid_o` is combinational from the registered FIFO head.
- **Throughput:** one grant per cycle while the FIFO is not full. `bus` returns responses one cycle after grant, so `MaxOutstanding` = 2 sustains back-to-back requests.
- **Registered state:** the only flops are the FIFO, `rr_ptr`, `lock`/`lock_id`, and `protocol_err_o`.

## Configuration
- **`BUS_HOST_ARB_ROUND_ROBIN_EN` defined:** round-robin arbitration exactly as described above.
- **`BUS_HOST_ARB_ROUND_ROBIN_EN` undefined:** fixed priority, where the lowest index wins. `rr_ptr` is removed and `sel` is the lowest requesting index. The lock and FIFO behaviour are unchanged.

## Test plan
- **Reset:** assert `rst_i` for 3 cycles with no requests. All outputs are 0, and `out_req_o` stays 0 after release.
- **Contention, round-robin:** hosts 0 and 1 request continuously with `out_gnt_i`=1. Grants alternate 0,1,0,1. Each `host_rvalid_o` pulse reaches its owner one cycle after that owner's grant, carrying `rdata` 0xA0000000+index.
- **Contention, fixed priority (macro undefined):** same stimulus as above. Host 0 receives every grant and host 1 is starved.
- **Lock:** host 1 requests with `out_gnt_i`=0 for 4 cycles, and host 0 raises its request in cycle 2. `out_addr_o` stays at host 1's address 0x00100010 until grant, and host 1 is granted first.
- **Full FIFO:** with `MaxOutstanding`=2, grant 2 requests while withholding `out_rvalid_i`. `out_req_o` = 0 while full. After one response, the next request is issued the following cycle. Responses 0xDEAD0001 and 0xDEAD0002 return in order with `out_err_i`=1 on the second, and `host_err_o` pulses only on that second response's owner.
- **Spurious response:** pulse `out_rvalid_i` with the FIFO empty. No `host_rvalid_o` is asserted, and `protocol_err_o` goes to 1 and stays 1 until `rst_i`.
